// File: rtl/mul_share_arbiter_if.sv
// Bundle of the requester, multiplier and result signals of mul_share_arbiter.
//   master : requester/multiplier side (drives requests and mul_result)
//   slave  : the arbiter (drives grants, operands, results and busy)
// Signals:
//   issue_en   global issue enable
//   req_valid  per-requester operand valid        req_ready  one-hot grant
//   req_a      packed 10-bit operands (i*10)      req_b      packed 18-bit operands (i*18)
//   mul_a/b    registered multiplier operands     mul_result multiplier product
//   res_valid  one-hot result strobe              res_data   product
//   res_id     owner index of res_data            busy       any tag in flight
interface mul_share_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic              issue_en;
  logic [N-1:0]      req_valid;
  logic [N*10-1:0]   req_a;
  logic [N*18-1:0]   req_b;
  logic [N-1:0]      req_ready;
  logic [9:0]        mul_a;
  logic [17:0]       mul_b;
  logic [27:0]       mul_result;
  logic [N-1:0]      res_valid;
  logic [27:0]       res_data;
  logic [IDW-1:0]    res_id;
  logic              busy;

  modport master (
    output issue_en, req_valid, req_a, req_b, mul_result,
    input  req_ready, mul_a, mul_b, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  issue_en, req_valid, req_a, req_b, mul_result,
    output req_ready, mul_a, mul_b, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Shares one external pipelined 10x18 multiplier (LAT cycles) among N
// requesters. One request is granted per cycle (round-robin or fixed
// priority), its operands are registered onto mul_a/mul_b, and a tag
// pipeline of LAT+1 stages carries the requester id so that each product is
// returned, in issue order, with a one-hot res_valid.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  mul_share_arbiter_if slave modport (requests, operands, results)
module mul_share_arbiter #(
  parameter int N         = 4,
  parameter int IDW       = 2,
  parameter int LAT       = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  mul_share_arbiter_if.slave   bus
);

  logic [N-1:0]   cand;
  logic [N-1:0]   grant;
  logic [IDW-1:0] gidx;
  logic [IDW-1:0] idx;
  logic           gfound;
  logic [9:0]     a_sel;
  logic [17:0]    b_sel;

  logic [IDW-1:0] rr_ptr_q;
  logic [9:0]     mul_a_q;
  logic [17:0]    mul_b_q;
  logic [LAT:0]   tag_vld_q;
  logic [IDW-1:0] tag_id_q [LAT+1];
  logic [N-1:0]   res_valid_q;
  logic [27:0]    res_data_q;
  logic [IDW-1:0] res_id_q;

  // Grant search: round-robin scans upward from rr_ptr with wrap, fixed
  // priority scans from index 0. First candidate found wins.
  always_comb begin
    cand   = bus.req_valid & {N{bus.issue_en}};
    gidx   = '0;
    idx    = '0;
    gfound = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (PRIO_MODE != 0) ? IDW'(k) : IDW'((32'(rr_ptr_q) + k) % N);
      if (!gfound && cand[idx]) begin
        gfound = 1'b1;
        gidx   = idx;
      end
    end
    grant = gfound ? (N'(1) << gidx) : '0;
    a_sel = '0;
    b_sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant[k]) begin
        a_sel = bus.req_a[k*10 +: 10];
        b_sel = bus.req_b[k*18 +: 18];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_vld_q   <= '0;
      for (int unsigned k = 0; k <= LAT; k++) tag_id_q[k] <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      // A grant is always a subset of req_valid, so gfound is the handshake.
      tag_vld_q[0] <= gfound;
      if (gfound) begin
        mul_a_q     <= a_sel;
        mul_b_q     <= b_sel;
        tag_id_q[0] <= gidx;
        rr_ptr_q    <= IDW'((32'(gidx) + 1) % N);
      end
      for (int unsigned k = 1; k <= LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
      if (tag_vld_q[LAT]) begin
        res_data_q  <= bus.mul_result;
        res_id_q    <= tag_id_q[LAT];
        res_valid_q <= N'(1) << tag_id_q[LAT];
      end else begin
        res_valid_q <= '0;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = |tag_vld_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [3:0]  vld;
  logic [9:0]  a [4];
  logic [17:0] b [4];

  always #5 clk = ~clk;

  mul_share_arbiter_if #(.N(N), .IDW(IDW)) ifr ();
  mul_share_arbiter_if #(.N(N), .IDW(IDW)) ifp ();

  mul_share_arbiter #(.N(N), .IDW(IDW), .LAT(LAT), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .bus(ifr));
  mul_share_arbiter #(.N(N), .IDW(IDW), .LAT(LAT), .PRIO_MODE(1)) u_fp (
    .clk(clk), .rst(rst), .bus(ifp));

  assign ifr.issue_en  = en;
  assign ifp.issue_en  = en;
  assign ifr.req_valid = vld;
  assign ifp.req_valid = vld;
  assign ifr.req_a     = {a[3], a[2], a[1], a[0]};
  assign ifp.req_a     = {a[3], a[2], a[1], a[0]};
  assign ifr.req_b     = {b[3], b[2], b[1], b[0]};
  assign ifp.req_b     = {b[3], b[2], b[1], b[0]};

  // 4-stage multiplier models, one per DUT
  logic [27:0] mpr [4];
  logic [27:0] mpp [4];
  always @(posedge clk) begin
    mpr[0] <= 28'(ifr.mul_a) * 28'(ifr.mul_b);
    mpp[0] <= 28'(ifp.mul_a) * 28'(ifp.mul_b);
    for (int k = 1; k < 4; k++) begin
      mpr[k] <= mpr[k-1];
      mpp[k] <= mpp[k-1];
    end
  end
  assign ifr.mul_result = mpr[3];
  assign ifp.mul_result = mpp[3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  bit mon_en = 1'b0;
  int rr_ptr_m = 0;

  typedef struct {
    int     id;
    longint data;
    int     due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    else passes++;
  endtask

  task automatic push_e(input int d, input exp_t e);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask
  function automatic int qsz(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction
  function automatic exp_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction
  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  function automatic int oh2i(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] model_grant(input logic [3:0] v, input logic e, input int mode, input int ptr);
    if (!e) return 4'b0;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (mode != 0) ? k : (ptr + k) % 4;
      if (v[i]) return 4'(1) << i;
    end
    return 4'b0;
  endfunction

  // Monitor: pops the scoreboard whenever a result shows up or is overdue.
  task automatic mon(input int d, input string nm, input logic [3:0] rv,
                     input logic [1:0] rid, input logic [27:0] rd, input logic bz);
    exp_t e;
    bit   exp_busy;
    if (rv != 4'b0 || (qsz(d) > 0 && qfront(d).due <= cyc)) begin
      if (qsz(d) == 0) begin
        chk({nm, " unexpected res_valid"}, 64'(rv), 64'd0);
      end else begin
        e = qfront(d);
        qpop(d);
        chk({nm, " res_valid"}, 64'(rv), 64'(4'(1) << e.id));
        chk({nm, " res_id"}, 64'(rid), 64'(e.id));
        chk({nm, " res_data"}, 64'(rd), 64'(e.data));
        chk({nm, " latency"}, 64'(cyc), 64'(e.due));
      end
    end
    exp_busy = (qsz(d) > 0) && (qfront(d).due - 5 <= cyc);
    chk({nm, " busy"}, 64'(bz), 64'(exp_busy));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, "rr", ifr.res_valid, ifr.res_id, ifr.res_data, ifr.busy);
      mon(1, "fp", ifp.res_valid, ifp.res_id, ifp.res_data, ifp.busy);
    end
  end

  // One cycle of stimulus, called at a negedge. hand=1: grants given by xr/xf.
  task automatic step(input logic r, input logic e_, input logic [3:0] v,
                      input logic [3:0] xr, input logic [3:0] xf, input bit hand);
    logic [3:0] gr, gf;
    exp_t ex;
    rst = r; en = e_; vld = v;
    #1;
    if (r) begin
      q0.delete();
      q1.delete();
      rr_ptr_m = 0;
    end else begin
      gr = hand ? xr : model_grant(v, e_, 0, rr_ptr_m);
      gf = hand ? xf : model_grant(v, e_, 1, 0);
      chk("rr req_ready", 64'(ifr.req_ready), 64'(gr));
      chk("fp req_ready", 64'(ifp.req_ready), 64'(gf));
      if (gr != 4'b0) begin
        ex.id   = oh2i(gr);
        ex.data = longint'(a[ex.id]) * longint'(b[ex.id]);
        ex.due  = cyc + 6;
        push_e(0, ex);
        rr_ptr_m = (ex.id + 1) % 4;
      end
      if (gf != 4'b0) begin
        ex.id   = oh2i(gf);
        ex.data = longint'(a[ex.id]) * longint'(b[ex.id]);
        ex.due  = cyc + 6;
        push_e(1, ex);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; vld = 4'b0;
    for (int i = 0; i < 4; i++) begin a[i] = '0; b[i] = '0; end
    repeat (3) @(negedge clk);

    chk("rr reset mul_a", 64'(ifr.mul_a), 64'd0);
    chk("rr reset mul_b", 64'(ifr.mul_b), 64'd0);
    chk("rr reset res_valid", 64'(ifr.res_valid), 64'd0);
    chk("rr reset res_data", 64'(ifr.res_data), 64'd0);
    chk("rr reset res_id", 64'(ifr.res_id), 64'd0);
    chk("rr reset busy", 64'(ifr.busy), 64'd0);
    chk("fp reset mul_a", 64'(ifp.mul_a), 64'd0);
    chk("fp reset res_valid", 64'(ifp.res_valid), 64'd0);
    chk("fp reset busy", 64'(ifp.busy), 64'd0);
    mon_en = 1'b1;

    // Max operands on requester 2 only: 1023*262143 = 268172289
    a[2] = 10'd1023; b[2] = 18'd262143;
    step(1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b1);
    repeat (7) step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    chk("max product seen", 64'(ifr.res_data), 64'd268172289);
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // All requesters valid continuously from rr_ptr=0
    for (int i = 0; i < 4; i++) begin
      a[i] = 10'(11 * (i + 1));
      b[i] = 18'(1000 * (i + 3) + i);
    end
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 4'hF, 4'(1) << (i % 4), 4'b0001, 1'b1);

    // issue_en low for 3 cycles mid-stream
    step(1'b0, 1'b1, 4'hF, 4'b0001, 4'b0001, 1'b1);
    step(1'b0, 1'b1, 4'hF, 4'b0010, 4'b0001, 1'b1);
    repeat (3) step(1'b0, 1'b0, 4'hF, 4'b0000, 4'b0000, 1'b1);
    step(1'b0, 1'b1, 4'hF, 4'b0100, 4'b0001, 1'b1);
    step(1'b0, 1'b1, 4'hF, 4'b1000, 4'b0001, 1'b1);
    step(1'b0, 1'b1, 4'hF, 4'b0001, 4'b0001, 1'b1);
    repeat (7) step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Reset with 3 products in flight and a request pending
    step(1'b0, 1'b1, 4'hF, 4'b0010, 4'b0001, 1'b1);
    step(1'b0, 1'b1, 4'hF, 4'b0100, 4'b0001, 1'b1);
    step(1'b0, 1'b1, 4'hF, 4'b1000, 4'b0001, 1'b1);
    step(1'b1, 1'b1, 4'hF, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 4'hF, 4'b0001, 4'b0001, 1'b1);
    repeat (7) step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1);

    // Random valid patterns, operands changing every cycle
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          a[i] = 10'd1023; b[i] = 18'd262143;
        end else begin
          a[i] = 10'($urandom); b[i] = 18'($urandom);
        end
      end
      step(1'b0, 1'($urandom_range(0, 7) != 0), 4'($urandom), 4'b0000, 4'b0000, 1'b0);
    end
    repeat (8) step(1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1);

    chk("rr scoreboard empty", 64'(q0.size()), 64'd0);
    chk("fp scoreboard empty", 64'(q1.size()), 64'd0);
    chk("rr final busy", 64'(ifr.busy), 64'd0);
    chk("fp final busy", 64'(ifp.busy), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
